// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption round sequencer with one shared SubBytes/ShiftRows unit.
// Optional key-wait timeout and key_err port: define AES_KEY_TIMEOUT_EN.

module sub_byte (
  input  logic [0:15][7:0] din,
  output logic [0:15][7:0] dout
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Row r of output column c comes from input column (c + r) mod 4 (ShiftRows).
  always_comb begin
    dout = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        dout[c*4+r] = SBOX[din[((c+r)%4)*4+r]];
  end
endmodule

module aes_round_ctrl #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:15][7:0] plaintext_in,
  input  logic             key_valid,
  input  logic [0:15][7:0] round_key,
  output logic             key_req,
  output logic [3:0]       key_round,
  output logic             busy,
  output logic             done,
  output logic [0:15][7:0] ciphertext_out
`ifdef AES_KEY_TIMEOUT_EN
  ,
  output logic             key_err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, KEY_WAIT = 2'd1, DONE = 2'd2} fsm_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_err
    $error("aes_round_ctrl: parameter out of legal range");
  end

  fsm_t             fsm, fsm_nxt;
  logic [3:0]       rnd;
  logic [0:15][7:0] state, sb_out, mc_out, rnd_out;
  logic             consume, last_rnd, timeout;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:15][7:0] mix_columns(input logic [0:15][7:0] s);
    logic [0:15][7:0] m;
    logic [7:0] a0, a1, a2, a3;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[c*4];
      a1 = s[c*4+1];
      a2 = s[c*4+2];
      a3 = s[c*4+3];
      m[c*4]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      m[c*4+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      m[c*4+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      m[c*4+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return m;
  endfunction

  sub_byte u_sub_byte (
    .din  (state),
    .dout (sb_out)
  );

  assign last_rnd  = (rnd == LAST_RND);
  assign consume   = (fsm == KEY_WAIT) && key_valid;
  assign key_round = rnd;

  // Round 0 is the whitening key add; the last round skips MixColumns.
  always_comb begin
    mc_out = mix_columns(sb_out);
    if (rnd == 4'd0)
      rnd_out = state ^ round_key;
    else if (last_rnd)
      rnd_out = sb_out ^ round_key;
    else
      rnd_out = mc_out ^ round_key;
  end

`ifdef AES_KEY_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  assign timeout = (fsm == KEY_WAIT) && !key_valid && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      key_err  <= 1'b0;
    end else begin
      key_err <= timeout;
      if (fsm != KEY_WAIT || key_valid)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      fsm <= IDLE;
    else
      fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    key_req = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (fsm)
      IDLE: begin
        busy = 1'b0;
        if (start) fsm_nxt = KEY_WAIT;
      end
      KEY_WAIT: begin
        key_req = 1'b1;
        if (consume && last_rnd) fsm_nxt = DONE;
        else if (timeout)        fsm_nxt = IDLE;
      end
      DONE: begin
        done    = 1'b1;
        fsm_nxt = IDLE;
      end
      default: begin
        busy    = 1'b0;
        fsm_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= '0;
      rnd            <= '0;
      ciphertext_out <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            state <= plaintext_in;
            rnd   <= '0;
          end
        end
        KEY_WAIT: begin
          if (consume) begin
            state <= rnd_out;
            if (last_rnd) ciphertext_out <= rnd_out;
            else          rnd <= rnd + 4'd1;
          end else if (timeout) begin
            state <= '0;
            rnd   <= '0;
          end
        end
        DONE:    rnd <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors, key stalls, restart, reset and back-to-back.
// Round keys are expanded here from an S-box derived from GF(2^8) inversion.

module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [0:15][7:0] plaintext_in;
  logic             key_valid = 1'b0;
  logic [0:15][7:0] round_key;
  logic             key_req;
  logic [3:0]       key_round;
  logic             busy;
  logic             done;
  logic [0:15][7:0] ciphertext_out;
`ifdef AES_KEY_TIMEOUT_EN
  logic             key_err;
`endif

  aes_round_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .plaintext_in   (plaintext_in),
    .key_valid      (key_valid),
    .round_key      (round_key),
    .key_req        (key_req),
    .key_round      (key_round),
    .busy           (busy),
    .done           (done),
    .ciphertext_out (ciphertext_out)
`ifdef AES_KEY_TIMEOUT_EN
    ,
    .key_err        (key_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  logic [7:0]   sbox [256];
  logic [127:0] rk_a [16];
  logic [127:0] rk_b [16];
  bit           use_b = 1'b0;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, input bit which);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      rk = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      if (which) rk_b[r] = rk;
      else       rk_a[r] = rk;
    end
  endtask

  always_comb round_key = use_b ? rk_b[key_round] : rk_a[key_round];

  // Key provider: 0 = always valid, 1 = three idle cycles before each key, 2 = withhold from round 3.
  int         kv_mode = 0;
  int         gap = 0;
  logic [3:0] seen_rounds [$];

  always @(negedge clk) begin
    case (kv_mode)
      0: key_valid = 1'b1;
      1: begin
        if (!key_req) begin
          key_valid = 1'b0;
          gap = 0;
        end else if (gap < 3) begin
          key_valid = 1'b0;
          gap++;
        end else begin
          key_valid = 1'b1;
          gap = 0;
        end
      end
      default: key_valid = key_req && (key_round < 4'd3);
    endcase
    if (key_req && key_valid) seen_rounds.push_back(key_round);
  end

  // Runs one block for a fixed window; lat = edges after the start-sampling edge until done.
  task automatic run_block(input logic [127:0] pt, input int restart_at, input int ncyc,
                           output int lat, output int ndone);
    @(negedge clk);
    plaintext_in = pt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    ndone = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'h0);
    chk({tag, "_done"}, 128'(done), 128'h0);
    chk({tag, "_key_req"}, 128'(key_req), 128'h0);
    chk({tag, "_key_round"}, 128'(key_round), 128'h0);
    chk({tag, "_ct"}, ciphertext_out, 128'h0);
`ifdef AES_KEY_TIMEOUT_EN
    chk({tag, "_key_err"}, 128'(key_err), 128'h0);
`endif
  endtask

  initial begin
    int lat, ndone, waits, errs, found;
    int stamps [$];

    rst = 1'b1;
    start = 1'b0;
    plaintext_in = '0;
    build_sbox();
    expand(KEY_A, 1'b0);
    expand(KEY_B, 1'b1);
    chk("sbox_53", 128'(sbox[8'h53]), 128'hed);
    chk("rk_b_r1", rk_b[1], 128'ha0fafe1788542cb123a339392a6c7605);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // FIPS-197 C.1, key always valid
    kv_mode = 0;
    use_b = 1'b0;
    run_block(PT_A, -1, 20, lat, ndone);
    chk("c1_latency", 128'(lat), 128'd11);
    chk("c1_done_cnt", 128'(ndone), 128'd1);
    chk("c1_ct", ciphertext_out, CT_A);
    chk("c1_busy_after", 128'(busy), 128'h0);

    // Appendix B with three stall cycles per round key
    @(negedge clk);
    kv_mode = 1;
    use_b = 1'b1;
    seen_rounds.delete();
    run_block(PT_B, -1, 55, lat, ndone);
    chk("b_latency", 128'(lat), 128'd44);
    chk("b_done_cnt", 128'(ndone), 128'd1);
    chk("b_ct", ciphertext_out, CT_B);
    chk("b_round_cnt", 128'(seen_rounds.size()), 128'd11);
    foreach (seen_rounds[k]) chk($sformatf("b_round_%0d", k), 128'(seen_rounds[k]), 128'(k));

    // Second start mid-block must be ignored
    @(negedge clk);
    kv_mode = 0;
    use_b = 1'b0;
    run_block(PT_A, 5, 25, lat, ndone);
    chk("restart_latency", 128'(lat), 128'd11);
    chk("restart_done_cnt", 128'(ndone), 128'd1);
    chk("restart_ct", ciphertext_out, CT_A);

    // Reset at round 5, then a fresh block
    use_b = 1'b1;
    @(negedge clk);
    plaintext_in = PT_B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (key_round == 4'd5) found = 1;
    end
    chk("rst_reached_rnd5", 128'(found), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    use_b = 1'b0;
    run_block(PT_A, -1, 20, lat, ndone);
    chk("midrst_latency", 128'(lat), 128'd11);
    chk("midrst_done_cnt", 128'(ndone), 128'd1);
    chk("midrst_ct", ciphertext_out, CT_A);

    // Back-to-back blocks with start held high
    @(negedge clk);
    plaintext_in = PT_A;
    start = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (done) begin
        stamps.push_back(i);
        chk("b2b_ct", ciphertext_out, CT_A);
      end
    end
    start = 1'b0;
    chk("b2b_done_cnt", 128'(stamps.size()), 128'd3);
    if (stamps.size() == 3) begin
      chk("b2b_first", 128'(stamps[0]), 128'd12);
      chk("b2b_period1", 128'(stamps[1] - stamps[0]), 128'd13);
      chk("b2b_period2", 128'(stamps[2] - stamps[1]), 128'd13);
    end
    repeat (20) @(negedge clk);
    chk("b2b_idle", 128'(busy), 128'h0);

`ifdef AES_KEY_TIMEOUT_EN
    // Key withheld at round 3 until the wait limit expires
    kv_mode = 2;
    @(negedge clk);
    plaintext_in = PT_B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waits = 0;
    errs = 0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_req && key_round == 4'd3) waits++;
      if (key_err) errs++;
      if (done) ndone++;
    end
    chk("to_wait_cycles", 128'(waits), 128'd16);
    chk("to_key_err_cnt", 128'(errs), 128'd1);
    chk("to_done_cnt", 128'(ndone), 128'd0);
    chk("to_ct_kept", ciphertext_out, CT_A);
    chk("to_busy", 128'(busy), 128'h0);
    chk("to_key_round", 128'(key_round), 128'h0);
    kv_mode = 0;
`else
    waits = 0;
    errs = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption round sequencer. Owns the 128-bit state register and steps one plaintext block through the initial AddRoundKey, nine full rounds and one final round. Uses one shared `sub_byte` instance (combinational SubBytes+ShiftRows) plus inline MixColumns and AddRoundKey. Round keys come from an external key schedule through a request/valid handshake, and the controller sits between the chip's block I/O and that key schedule.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: number of cipher rounds after the initial AddRoundKey. Legal range is 1..15.
- `TIMEOUT_CYCLES`, default 16: key-wait limit. It is used only when `AES_KEY_TIMEOUT_EN` is defined. Legal range is 2..255.

Ports:
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, **synchronous, active-high**.
- `start`, in, 1: start request. It is sampled only in IDLE.
- `plaintext_in`, in, [0:15][7:0]: input block. Byte 0 is the first byte of the block. Layout is column-major: byte i is in column i/4, row i%4.
- `key_valid`, in, 1: `round_key` is valid for the current `key_round`.
- `round_key`, in, [0:15][7:0]: round key, same layout as `plaintext_in`.
- `key_req`, out, 1: round key requested.
- `key_round`, out, 4: index of the requested round key, 0..NUM_ROUNDS.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `ciphertext_out`, out, [0:15][7:0]: result register.
- `key_err`, out, 1: exists only with `AES_KEY_TIMEOUT_EN`. One-cycle abort pulse.

## Operation
FSM has three states: IDLE, KEY_WAIT, DONE. A 4-bit round counter `rnd` drives `key_round` directly.
- IDLE:
  - On `start`=1, load `state` from `plaintext_in`, set `rnd`=0, go to KEY_WAIT.
  - Otherwise hold.
- KEY_WAIT:
  - `key_req`=1 throughout.
  - On a cycle with `key_valid`=1, the controller consumes `round_key` and updates `state`:
    - `rnd`=0: `state` ← `state` ^ `round_key`.
    - 1 ≤ `rnd` < NUM_ROUNDS: `state` ← MixColumns(`sub_byte`(`state`)) ^ `round_key`.
    - `rnd`=NUM_ROUNDS: `state` ← `sub_byte`(`state`) ^ `round_key`. The same value is written to `ciphertext_out`. Go to DONE.
  - After a non-final update, `rnd` increments and the FSM stays in KEY_WAIT. `key_req` stays high, and `key_round` shows the new index from the next cycle.
  - With `key_valid`=0, hold `state` and `rnd`.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- MixColumns uses standard GF(2^8) with xtime reduction polynomial 0x1b, applied per column of 4 bytes.
- `start` while `busy` is ignored. There is no queueing.
- `ciphertext_out` holds its value until the next completed block. It is not cleared by `start`.
- The key provider may assert `key_valid` in the same cycle it sees `key_req`/`key_round`, so a combinational ROM is allowed. `key_valid` while `key_req`=0 is ignored.

## Timing
- Reset, whenever `rst` is high at a clock edge, including mid-block:
  - FSM goes to IDLE and `rnd` to 0.
  - `state`, `ciphertext_out`, `key_req`, `key_round`, `busy`, `done` and `key_err` all go to 0.
  - A block in flight is discarded and no `done` is produced.
- Minimum latency, with `key_valid` held high:
  - `start` sampled at edge T.
  - KEY_WAIT occupies T+1..T+NUM_ROUNDS+1.
  - `done` and a valid `ciphertext_out` appear in cycle T+NUM_ROUNDS+2. For AES-128 that is 12 cycles.
- Each cycle without `key_valid` adds one cycle of latency.
- `start` in the DONE cycle is ignored. The earliest next accept is in the following IDLE cycle.

## Configuration
- `AES_KEY_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to KEY_WAIT and on every consumed key, and increments on each KEY_WAIT cycle without `key_valid`.
  - When it reaches TIMEOUT_CYCLES, the controller pulses `key_err` for one cycle, goes to IDLE, and clears `state` and `rnd`. `done` is not asserted and `ciphertext_out` is unchanged.
- `AES_KEY_TIMEOUT_EN` undefined: the `key_err` port and the counter are absent, and KEY_WAIT waits indefinitely.

## Test plan
- FIPS-197 C.1 vector, `key_valid` tied high, bench supplies expanded keys of key 000102…0f, plaintext 00112233445566778899aabbccddeeff → `done` 12 cycles after `start`, `ciphertext_out` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 Appendix B, key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, with `key_valid` low for 3 random cycles per round → `ciphertext_out` = 3925841d02dc09fbdc118597196a0b32, and `key_round` steps 0..10 with no skips or repeats.
- Second `start` pulsed in the middle of a block → ignored, result identical to the first case, exactly one `done`.
- `rst` asserted at `rnd`=5, then a new `start` → all outputs 0 in the cycle after reset, then the new block completes correctly with a single `done`.
- Back-to-back blocks, `start` held high → the second block is accepted in the IDLE cycle after DONE, giving one block per 13 cycles.
- With `AES_KEY_TIMEOUT_EN` and TIMEOUT_CYCLES=16, `key_valid` withheld at `rnd`=3 → `key_err` pulses after 16 waiting cycles, FSM returns to IDLE, no `done`, `ciphertext_out` unchanged.
